// File: rtl/grads_stream_if.sv
// Stream bundle around the gradient controller: window-side handshake in,
// datapath results in, pixel stream out.
interface grads_stream_if;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tuser;
  logic        s_axis_tlast;
  logic [7:0]  gx;
  logic [7:0]  gy;
  logic [7:0]  gxgy;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;

  // Controller view: consumes windows and gradients, produces the pixel stream.
  modport slave (
    input  s_axis_tvalid, s_axis_tuser, s_axis_tlast, gx, gy, gxgy, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );

  // Environment view: window-buffer stage upstream plus the downstream consumer.
  modport master (
    output s_axis_tvalid, s_axis_tuser, s_axis_tlast, gx, gy, gxgy, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );
endinterface

// File: rtl/grads_stream_ctrl.sv
// Frame sequencer for the 3x3 gradient datapath: position tracking, border zeroing,
// sideband regeneration, single-register output stage and framing error flags.
module grads_stream_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CNT_W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  grads_stream_if.slave  st,
  output logic           frame_done,
  output logic           err_sof,
  output logic           err_line
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   col_q, col_d;
  logic [CNT_W-1:0]   row_q, row_d;
  logic               m_valid_q, m_valid_d;
  logic [23:0]        m_data_q, m_data_d;
  logic               m_user_q, m_user_d;
  logic               m_last_q, m_last_d;
  logic               frame_done_q, frame_done_d;
  logic               err_sof_q, err_sof_d;
  logic               err_line_q, err_line_d;

  logic               s_ready;
  logic               s_fire;
  logic               m_fire;
  logic               take;
  logic [CNT_W-1:0]   beat_col;
  logic [CNT_W-1:0]   beat_row;
  logic               col_end;
  logic               row_end;
  logic               border;

  // Upstream holds the window (and hence gx/gy/gxgy) while stalled, so loading on
  // s_fire alone captures the right gradients without a datapath enable.
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      IDLE:    s_ready = st.s_axis_tvalid && (!st.s_axis_tuser || enable);
      RUN:     s_ready = !m_valid_q || st.m_axis_tready;
      default: s_ready = 1'b0;
    endcase
  end

  assign s_fire   = st.s_axis_tvalid && s_ready;
  assign m_fire   = m_valid_q && st.m_axis_tready;
  // Non-SOF beats accepted in IDLE are swallowed without producing output.
  assign take     = s_fire && ((state_q == RUN) || st.s_axis_tuser);
  assign beat_col = st.s_axis_tuser ? '0 : col_q;
  assign beat_row = st.s_axis_tuser ? '0 : row_q;
  assign col_end  = (beat_col == COL_LAST);
  assign row_end  = (beat_row == ROW_LAST);
  assign border   = (beat_col == '0) || col_end || (beat_row == '0) || row_end;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_user_d     = m_user_q;
    m_last_d     = m_last_q;
    frame_done_d = 1'b0;
    err_sof_d    = err_sof_q;
    err_line_d   = err_line_q;

    if (m_fire) m_valid_d = 1'b0;

    if (take) begin
      m_valid_d = 1'b1;
      m_data_d  = border ? 24'h0 : {st.gxgy, st.gy, st.gx};
      m_user_d  = (beat_col == '0) && (beat_row == '0);
      m_last_d  = col_end;
      if (state_q == RUN && st.s_axis_tuser) err_sof_d = 1'b1;
      if (st.s_axis_tlast != col_end) err_line_d = 1'b1;
      // Position follows the column count; a misplaced tlast only raises the flag.
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : beat_row + CNT_W'(1);
      end else begin
        col_d = beat_col + CNT_W'(1);
        row_d = beat_row;
      end
      state_d = (col_end && row_end) ? DRAIN : RUN;
    end

    if (state_q == DRAIN && m_fire) begin
      state_d      = IDLE;
      frame_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= 24'h0;
      m_user_q     <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_sof_q    <= 1'b0;
      err_line_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_user_q     <= m_user_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
      err_sof_q    <= err_sof_d;
      err_line_q   <= err_line_d;
    end
  end

  assign st.s_axis_tready = s_ready;
  assign st.m_axis_tvalid = m_valid_q;
  assign st.m_axis_tdata  = m_data_q;
  assign st.m_axis_tuser  = m_user_q;
  assign st.m_axis_tlast  = m_last_q;
  assign frame_done       = frame_done_q;
  assign err_sof          = err_sof_q;
  assign err_line         = err_line_q;

endmodule

// File: tb/tb_grads_stream_ctrl.sv
// Bench for grads_stream_ctrl on a 4x3 image: a frame-position reference model
// builds the expected pixel stream, a monitor records what the DUT emits.
module tb_grads_stream_ctrl;
  localparam int W = 4;
  localparam int H = 3;

  typedef struct packed {
    logic [23:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic clk;
  logic rst;
  logic enable;
  logic frame_done;
  logic err_sof;
  logic err_line;

  grads_stream_if sif();

  grads_stream_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .st         (sif.slave),
    .frame_done (frame_done),
    .err_sof    (err_sof),
    .err_line   (err_line)
  );

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    checks = 0;
  int    errors = 0;
  int    timeouts = 0;
  int    done_cnt = 0;
  int    stall_changes = 0;
  int    rdy_mode = 0;

  // Reference model state: linear pixel index inside the current frame.
  bit    m_in_frame;
  int    m_pos;
  bit    e_sof;
  bit    e_line;
  int    e_frames;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_in_frame = 0;
    m_pos      = 0;
    e_sof      = 0;
    e_line     = 0;
    e_frames   = 0;
    exp_q.delete();
  endfunction

  function automatic void model_beat(input bit u, input bit l, input logic [23:0] d);
    int    col;
    int    row;
    beat_t b;
    if (!m_in_frame && !u) return;
    if (m_in_frame && u) e_sof = 1;
    if (u) m_pos = 0;
    m_in_frame = 1;
    col = m_pos % W;
    row = m_pos / W;
    b.d = (col == 0 || col == W-1 || row == 0 || row == H-1) ? 24'h0 : d;
    b.u = (m_pos == 0);
    b.l = (col == W-1);
    if (l != b.l) e_line = 1;
    exp_q.push_back(b);
    m_pos++;
    if (m_pos == W*H) begin
      m_in_frame = 0;
      m_pos      = 0;
      e_frames++;
    end
  endfunction

  // Downstream ready pattern: 0 = always ready, 1 = toggling, 2 = random.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       sif.m_axis_tready = 1'b1;
        1:       sif.m_axis_tready = !sif.m_axis_tready;
        default: sif.m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    beat_t prev;
    bit    prev_stall;
    prev = '0;
    prev_stall = 0;
    forever begin
      @(negedge clk);
      if (rst) prev_stall = 0;
      else begin
        if (prev_stall && (!sif.m_axis_tvalid ||
            {sif.m_axis_tdata, sif.m_axis_tuser, sif.m_axis_tlast} !== prev))
          stall_changes++;
        if (sif.m_axis_tvalid && sif.m_axis_tready)
          obs_q.push_back({sif.m_axis_tdata, sif.m_axis_tuser, sif.m_axis_tlast});
        prev = {sif.m_axis_tdata, sif.m_axis_tuser, sif.m_axis_tlast};
        prev_stall = sif.m_axis_tvalid && !sif.m_axis_tready;
        if (frame_done) done_cnt++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    sif.s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    obs_q.delete();
    done_cnt = 0;
    stall_changes = 0;
    timeouts = 0;
  endtask

  task automatic send_beat(input bit u, input bit l, input logic [23:0] d);
    bit ok;
    ok = 0;
    sif.s_axis_tvalid = 1'b1;
    sif.s_axis_tuser  = u;
    sif.s_axis_tlast  = l;
    {sif.gxgy, sif.gy, sif.gx} = d;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (sif.s_axis_tready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    sif.s_axis_tvalid = 1'b0;
    if (ok) model_beat(u, l, d);
    else timeouts++;
  endtask

  task automatic send_frame(input bit rnd, input int gap_pct);
    for (int i = 0; i < W*H; i++) begin
      send_beat(i == 0, (i % W) == W-1, rnd ? 24'($urandom) : 24'h302010);
      if ($urandom_range(0, 99) < gap_pct) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (obs_q.size() < exp_q.size() && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (t >= 500) timeouts++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    sif.s_axis_tuser = 1'b0;
    sif.s_axis_tlast = 1'b0;
    {sif.gxgy, sif.gy, sif.gx} = 24'h0;
    sif.m_axis_tready = 1'b1;
    do_reset();
    @(negedge clk);
    checks++; if (sif.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", sif.m_axis_tvalid); end
    checks++; if (sif.m_axis_tdata !== 24'h0) begin errors++; $display("FAIL rst_tdata got %h want 000000", sif.m_axis_tdata); end
    checks++; if ({sif.m_axis_tuser, sif.m_axis_tlast} !== 2'b00) begin errors++; $display("FAIL rst_side got %b want 00", {sif.m_axis_tuser, sif.m_axis_tlast}); end
    checks++; if ({frame_done, err_sof, err_line} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {frame_done, err_sof, err_line}); end
    checks++; if (sif.s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b want 0", sif.s_axis_tready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    rdy_mode = 0;
    do_reset();
    send_frame(0, 0);
    wait_drain();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() == W*H) begin
      checks++; if (obs_q[5].d !== 24'h302010 || obs_q[6].d !== 24'h302010) begin errors++; $display("FAIL basic_inner got %h/%h want 302010", obs_q[5].d, obs_q[6].d); end
      checks++; if ({obs_q[0].u, obs_q[3].l, obs_q[7].l, obs_q[11].l} !== 4'b1111) begin errors++; $display("FAIL basic_side got %b want 1111", {obs_q[0].u, obs_q[3].l, obs_q[7].l, obs_q[11].l}); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done got %0d want 1", done_cnt); end
    checks++; if ({err_sof, err_line} !== 2'b00) begin errors++; $display("FAIL basic_err got %b want 00", {err_sof, err_line}); end
    checks++; if (timeouts !== 0) begin errors++; $display("FAIL basic_timeout got %0d want 0", timeouts); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_mode = 1;
    send_frame(1, 0);
    wait_drain();
    rdy_mode = 0;
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (stall_changes !== 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stall_changes); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done got %0d want 1", done_cnt); end
    checks++; if (timeouts !== 0) begin errors++; $display("FAIL bp_timeout got %0d want 0", timeouts); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] d;
    bit          u;
    bit          l;
    rdy_mode = 0;
    do_reset();
    for (int i = 0; i < W*H; i++) begin
      u = (i == 0);
      l = (i % W) == W-1;
      d = 24'($urandom);
      sif.s_axis_tvalid = 1'b1;
      sif.s_axis_tuser  = u;
      sif.s_axis_tlast  = l;
      {sif.gxgy, sif.gy, sif.gx} = d;
      @(negedge clk);
      checks++; if (sif.s_axis_tready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b want 1", i, sif.s_axis_tready); end
      if (i == 0) begin
        checks++; if (sif.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL b2b_early got %b want 0", sif.m_axis_tvalid); end
      end else begin
        checks++; if (sif.m_axis_tvalid !== 1'b1 || {sif.m_axis_tdata, sif.m_axis_tuser, sif.m_axis_tlast} !== exp_q[i-1])
          begin errors++; $display("FAIL b2b_beat%0d got v=%b %h want v=1 %h", i-1, sif.m_axis_tvalid, {sif.m_axis_tdata, sif.m_axis_tuser, sif.m_axis_tlast}, exp_q[i-1]); end
      end
      @(posedge clk); #1;
      model_beat(u, l, d);
    end
    sif.s_axis_tvalid = 1'b0;
    @(negedge clk);
    checks++; if (sif.m_axis_tvalid !== 1'b1 || {sif.m_axis_tdata, sif.m_axis_tuser, sif.m_axis_tlast} !== exp_q[W*H-1])
      begin errors++; $display("FAIL b2b_last got v=%b %h want v=1 %h", sif.m_axis_tvalid, {sif.m_axis_tdata, sif.m_axis_tuser, sif.m_axis_tlast}, exp_q[W*H-1]); end
    @(posedge clk); #1;
    wait_drain();
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_sof_mid();
    int p;
    rdy_mode = 0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      p = (i < 5) ? i : i - 5;
      send_beat(i == 0 || i == 5, (p % W) == W-1, 24'($urandom));
    end
    wait_drain();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL sof_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL sof_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() > 5) begin
      checks++; if (obs_q[5].u !== 1'b1) begin errors++; $display("FAIL sof_restart got tuser=%b want 1", obs_q[5].u); end
    end
    checks++; if ({err_sof, err_line} !== {e_sof, e_line} || err_sof !== 1'b1) begin errors++; $display("FAIL sof_err got %b want %b", {err_sof, err_line}, {e_sof, e_line}); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL sof_done got %0d want 1", done_cnt); end
    checks++; if (timeouts !== 0) begin errors++; $display("FAIL sof_timeout got %0d want 0", timeouts); end
  endtask

  task automatic test_tlast_err();
    rdy_mode = 0;
    do_reset();
    for (int i = 0; i < W*H; i++)
      send_beat(i == 0, (i == 2) || ((i % W) == W-1 && i != 3), 24'($urandom));
    wait_drain();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL line_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL line_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() > 4) begin
      checks++; if ({obs_q[2].l, obs_q[3].l, obs_q[4].l} !== 3'b010) begin errors++; $display("FAIL line_wrap got %b want 010", {obs_q[2].l, obs_q[3].l, obs_q[4].l}); end
    end
    checks++; if ({err_sof, err_line} !== 2'b01) begin errors++; $display("FAIL line_err got %b want 01", {err_sof, err_line}); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL line_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_rst_mid();
    logic [23:0] d;
    rdy_mode = 0;
    do_reset();
    for (int i = 0; i < 6; i++)
      send_beat(i == 0, (i == 1) || (i % W) == W-1, 24'($urandom));
    checks++; if (err_line !== e_line) begin errors++; $display("FAIL rstmid_pre_err got %b want %b", err_line, e_line); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({sif.m_axis_tvalid, sif.m_axis_tdata, sif.m_axis_tuser, sif.m_axis_tlast} !== 27'h0)
      begin errors++; $display("FAIL rstmid_out got v=%b %h want all 0", sif.m_axis_tvalid, sif.m_axis_tdata); end
    checks++; if ({err_sof, err_line, frame_done} !== 3'b000) begin errors++; $display("FAIL rstmid_flags got %b want 000", {err_sof, err_line, frame_done}); end
    @(posedge clk); #1;
    model_reset();
    obs_q.delete();
    done_cnt = 0;
    timeouts = 0;
    for (int i = 0; i < 3; i++) send_beat(0, 0, 24'($urandom));
    repeat (3) @(posedge clk); #1;
    checks++; if (obs_q.size() !== 0 || timeouts !== 0) begin errors++; $display("FAIL rstmid_drop got %0d beats %0d timeouts want 0 0", obs_q.size(), timeouts); end
    enable = 1'b0;
    d = 24'($urandom);
    sif.s_axis_tvalid = 1'b1;
    sif.s_axis_tuser  = 1'b1;
    sif.s_axis_tlast  = 1'b0;
    {sif.gxgy, sif.gy, sif.gx} = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (sif.s_axis_tready !== 1'b0) begin errors++; $display("FAIL rstmid_hold%0d got %b want 0", i, sif.s_axis_tready); end
      @(posedge clk); #1;
    end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (sif.s_axis_tready !== 1'b1) begin errors++; $display("FAIL rstmid_sof got %b want 1", sif.s_axis_tready); end
    @(posedge clk); #1;
    sif.s_axis_tvalid = 1'b0;
    model_beat(1, 0, d);
    for (int i = 1; i < W*H; i++) send_beat(0, (i % W) == W-1, 24'($urandom));
    wait_drain();
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rstmid_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) begin
      send_frame(1, 30);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) send_beat(0, 1'($urandom_range(0, 1)), 24'($urandom));
    end
    wait_drain();
    rdy_mode = 0;
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt !== e_frames) begin errors++; $display("FAIL rand_done got %0d want %0d", done_cnt, e_frames); end
    checks++; if (stall_changes !== 0) begin errors++; $display("FAIL rand_stable got %0d changes want 0", stall_changes); end
    checks++; if ({err_sof, err_line} !== {e_sof, e_line}) begin errors++; $display("FAIL rand_err got %b want %b", {err_sof, err_line}, {e_sof, e_line}); end
    checks++; if (timeouts !== 0) begin errors++; $display("FAIL rand_timeout got %0d want 0", timeouts); end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    sif.s_axis_tvalid = 1'b0;
    sif.m_axis_tready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_back_to_back();
    test_sof_mid();
    test_tlast_err();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
